child_rr_scheduler: RTL and testbench
=====================================

Name: child_rr_scheduler

Overview:
Round-robin scheduler that shares one common resource slot among the five child instances of a hierarchy node (indices 0..4).
- Each child raises a request; the block grants exactly one child at a time.
- A grant is held until the child signals done or a watchdog timeout expires.
- The block sits beside the child instances in the parent module and is the only source of grant signals to them.

Parameters:
NUM_REQ, 5, number of requesting child instances (supported range 2..8)
TIMEOUT, 16, maximum cycles a grant may be held before forced release (range 1..255)
IDX_W, $clog2(NUM_REQ), width of grant index
CNT_W, 8, width of watchdog counter and grant counter

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-child request level
done  input  NUM_REQ  per-child completion pulse
gnt  output  NUM_REQ  one-hot grant, registered
gnt_idx  output  IDX_W  index of current grant; valid only while busy=1
busy  output  1  high while any grant is held
timeout_pulse  output  1  one-cycle pulse on forced release
grant_count  output  CNT_W  total grants issued, wraps at 2^CNT_W

Behaviour:
- Reset: async assert on rst_n low, sync-style release.
  - gnt=0, gnt_idx=0, busy=0, timeout_pulse=0, grant_count=0.
  - Round-robin pointer last_idx = NUM_REQ-1, so child 0 has first priority.
  - Watchdog counter = 0. FSM = IDLE.
- FSM states: IDLE, BUSY.
- IDLE:
  - If req != 0 in cycle N, search from last_idx+1 upward, wrapping mod NUM_REQ, for the first set bit k.
  - In cycle N+1: gnt = one-hot(k), gnt_idx = k, busy = 1, last_idx = k, grant_count += 1, watchdog = 0, state = BUSY.
  - If req == 0: stay in IDLE, outputs unchanged.
- BUSY:
  - Watchdog increments each cycle.
  - If done[gnt_idx]=1: gnt=0 and busy=0 next cycle, state = IDLE.
  - Else if watchdog == TIMEOUT-1: gnt=0, busy=0, timeout_pulse=1 for exactly one cycle, state = IDLE.
  - The watchdog check is reached at the end of the TIMEOUT-th cycle of the grant.
  - done and timeout in the same cycle: done wins, no timeout_pulse.
- Grant gap: after any release there is at least one cycle with gnt=0 before the next grant. IDLE always takes one cycle to arbitrate, so back-to-back grants are separated by exactly 1 idle cycle.
- Ignored inputs:
  - done bits for non-granted indices are ignored in all states.
  - done is ignored in IDLE.
  - req deasserting during BUSY does not drop the grant; the grant holds until done or timeout.
- Fairness: a child that was just granted has the lowest priority at the next arbitration. With all requests held continuously, the grant order is 0,1,2,3,4,0,...
- req bits at indices >= NUM_REQ do not exist; the wrap uses modulo NUM_REQ, not a power of 2.
- grant_count wraps from 2^CNT_W-1 to 0 silently.
- Reset asserted mid-grant: gnt drops immediately (asynchronously). No timeout_pulse and no done is required.
- Invariant: gnt is always zero or one-hot.

Decomposition:
- Shared package child_sched_pkg holds:
  - sched_state_e enum {IDLE, BUSY}
  - a default TIMEOUT localparam
  - a function rr_pick(req, last_idx) returning {found, idx}
- One natural sub-module: rr_pick_comb. It is the purely combinational rotating priority search, reusable by other hierarchy nodes with different NUM_REQ.
- FSM, watchdog and counters stay in the top.

Test Plan:
- Reset, then req=5'b00100 for 1 cycle -> gnt=5'b00100 and gnt_idx=2 one cycle later; busy=1; grant_count=1.
- req=5'b11111 held; each grant released by a done pulse one cycle after gnt -> grant order 0,1,2,3,4,0; exactly one gnt=0 cycle between grants.
- req=5'b00010, no done, TIMEOUT=16 -> gnt=5'b00010 held 16 cycles, then gnt=0 with timeout_pulse=1 for exactly one cycle.
- Grant to child 3; done=5'b00001 (wrong child) -> no release. Then done=5'b01000 coinciding with the watchdog limit -> release with timeout_pulse=0.
- Grant to child 4, then rst_n pulsed low mid-grant -> gnt=0 immediately; after release, req=5'b10001 -> child 0 granted first (pointer reset).
- Issue 256 grants with CNT_W=8 -> grant_count wraps to 0; gnt is never non-one-hot (assertion checked every cycle).

Source files
------------

// File: rtl/child_sched_pkg.sv
// Shared types and helpers for hierarchy-node child schedulers.
// rr_pick is sized for the widest supported node and narrowed by the caller.
package child_sched_pkg;

  localparam int MAX_REQ     = 8;
  localparam int MAX_IDX_W   = 3;
  localparam int DEF_NUM_REQ = 5;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set request strictly after last_idx, wrapping modulo n.
  // With a single requester equal to last_idx it is picked again on the n-th step.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                       input logic [MAX_IDX_W-1:0] last_idx,
                                       input int                   n);
    rr_pick_t r;
    int       k;
    r = '0;
    k = 0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= n && !r.found) begin
        k = (int'(last_idx) + i) % n;
        if (req[k[MAX_IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = k[MAX_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotating-priority search; reusable for any node width 2..8.
module rr_pick_comb
  import child_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_idx_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  rr_pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_REQ'(req_i), MAX_IDX_W'(last_idx_i), NUM_REQ);
    found_o = pick.found;
    idx_o   = pick.idx[IDX_W-1:0];
  end

endmodule

// File: rtl/child_rr_scheduler.sv
// Round-robin owner of one shared resource slot among the children of a node.
// A grant lasts until the owner's done pulse or the watchdog limit, whichever first.
module child_rr_scheduler
  import child_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] done_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               busy_o,
  output logic               timeout_pulse_o,
  output logic [CNT_W-1:0]   grant_count_o
);

  localparam logic [CNT_W-1:0]   WDOG_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

  sched_state_e         state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     wdog_q, wdog_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 owner_done;

  rr_pick_comb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i      (req_i),
    .last_idx_i (last_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  // gnt_q is zero or one-hot, so masking isolates the owner's done bit.
  assign owner_done = |(done_i & gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          gnt_d   = ONE << pick_idx;
          idx_d   = pick_idx;
          last_d  = pick_idx;
          wdog_d  = '0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      BUSY: begin
        wdog_d = wdog_q + CNT_W'(1);
        if (owner_done) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = IDLE;
          gnt_d   = '0;
          tmo_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= LAST_RST;
      wdog_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign gnt_idx_o       = idx_q;
  assign busy_o          = (state_q == BUSY);
  assign timeout_pulse_o = tmo_q;
  assign grant_count_o   = cnt_q;

endmodule

// File: tb/tb_child_rr_scheduler.sv
// Self-checking bench for child_rr_scheduler: directed scenarios plus a
// randomized run compared against an ownership/hold-time model.
module tb_child_rr_scheduler;

  localparam int NR  = 5;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] req = '0;
  logic [4:0] done = '0;
  logic [4:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       tmo;
  logic [7:0] cnt;

  int vectors = 0;
  int miscompares = 0;

  // Model: who owns the slot, for how many visible cycles, who was served last.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_held;
  int m_cnt;
  bit m_tmo;

  child_rr_scheduler #(
    .NUM_REQ (NR),
    .TIMEOUT (TMO),
    .IDX_W   (3),
    .CNT_W   (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req),
    .done_i          (done),
    .gnt_o           (gnt),
    .gnt_idx_o       (gnt_idx),
    .busy_o          (busy),
    .timeout_pulse_o (tmo),
    .grant_count_o   (cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (!$onehot0(gnt)) begin
        miscompares++;
        $display("FAIL onehot: gnt=%b is not zero/one-hot", gnt);
      end
    end
  end

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = NR - 1; m_held = 0; m_cnt = 0; m_tmo = 0;
  endtask

  task automatic model_step(input logic [4:0] r, input logic [4:0] d);
    m_tmo = 0;
    if (!m_busy) begin
      for (int i = 1; i <= NR; i++) begin
        if (!m_busy && r[(m_last + i) % NR]) begin
          m_owner = (m_last + i) % NR;
          m_last  = m_owner;
          m_busy  = 1;
          m_held  = 1;
          m_cnt   = (m_cnt + 1) % 256;
        end
      end
    end else if (d[m_owner]) begin
      m_busy = 0;
    end else if (m_held == TMO) begin
      m_busy = 0;
      m_tmo  = 1;
    end else begin
      m_held++;
    end
  endtask

  task automatic cyc(input logic [4:0] r, input logic [4:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic do_reset();
    req = '0; done = '0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5'b0, 5'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 5'b11111;
    done  = 5'b11111;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({gnt, gnt_idx, busy, tmo, cnt} !== 18'b0) begin
      miscompares++;
      $display("FAIL reset_state: gnt=%b idx=%0d busy=%b tmo=%b cnt=%0d, want all zero",
               gnt, gnt_idx, busy, tmo, cnt);
    end
    req = '0; done = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(5'b0, 5'b0);
    vectors++;
    if (busy !== 1'b0 || gnt !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b gnt=%b with no requests", busy, gnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    cyc(5'b00100, 5'b0);
    vectors++;
    if (gnt !== 5'b00100 || gnt_idx !== 3'd2 || busy !== 1'b1 || cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL single_grant: gnt=%b idx=%0d busy=%b cnt=%0d, want 00100/2/1/1",
               gnt, gnt_idx, busy, cnt);
    end
    cyc(5'b0, 5'b00100);
    vectors++;
    if (gnt !== 5'b0 || busy !== 1'b0 || tmo !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release: gnt=%b busy=%b tmo=%b, want 0/0/0", gnt, busy, tmo);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] e;
    do_reset();
    for (int g = 0; g < 6; g++) begin
      e = 5'b00001 << (g % NR);
      cyc(5'b11111, 5'b0);
      vectors++;
      if (gnt !== e || gnt_idx !== 3'(g % NR)) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: gnt=%b idx=%0d, want %b", g, gnt, gnt_idx, e);
      end
      cyc(5'b11111, gnt);
      vectors++;
      if (gnt !== 5'b0) begin
        miscompares++;
        $display("FAIL rr_gap[%0d]: gnt=%b, want 00000", g, gnt);
      end
    end
  endtask

  task automatic test_timeout();
    int hi;
    int pulses;
    do_reset();
    hi = 0;
    pulses = 0;
    cyc(5'b00010, 5'b0);
    for (int c = 0; c < 40; c++) begin
      if (gnt === 5'b00010) hi++;
      if (tmo === 1'b1) begin
        pulses++;
        vectors++;
        if (gnt !== 5'b0 || hi != TMO) begin
          miscompares++;
          $display("FAIL timeout_edge: gnt=%b held=%0d at pulse, want 00000/%0d", gnt, hi, TMO);
        end
      end
      cyc(5'b0, 5'b0);
    end
    vectors++;
    if (hi != TMO) begin
      miscompares++;
      $display("FAIL timeout_hold: held %0d cycles, want %0d", hi, TMO);
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL timeout_pulse: %0d pulse cycles, want 1", pulses);
    end
  endtask

  task automatic test_wrong_done();
    bit held_ok;
    do_reset();
    cyc(5'b01000, 5'b0);
    vectors++;
    if (gnt !== 5'b01000) begin
      miscompares++;
      $display("FAIL wd_grant: gnt=%b, want 01000", gnt);
    end
    held_ok = 1;
    for (int c = 1; c < TMO; c++) begin
      cyc(5'b0, 5'b10111 & 5'($urandom) | 5'b00001);
      if (gnt !== 5'b01000 || busy !== 1'b1) held_ok = 0;
    end
    vectors++;
    if (!held_ok) begin
      miscompares++;
      $display("FAIL wd_ignore: grant dropped on foreign done, gnt=%b", gnt);
    end
    cyc(5'b0, 5'b01000);
    vectors++;
    if (gnt !== 5'b0 || busy !== 1'b0 || tmo !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_done_wins: gnt=%b busy=%b tmo=%b, want 0/0/0", gnt, busy, tmo);
    end
    cyc(5'b0, 5'b0);
    vectors++;
    if (tmo !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_late_pulse: tmo=%b, want 0", tmo);
    end
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    cyc(5'b10000, 5'b0);
    vectors++;
    if (gnt !== 5'b10000) begin
      miscompares++;
      $display("FAIL mr_grant: gnt=%b, want 10000", gnt);
    end
    cyc(5'b0, 5'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (gnt !== 5'b0 || busy !== 1'b0 || tmo !== 1'b0) begin
      miscompares++;
      $display("FAIL mr_async: gnt=%b busy=%b tmo=%b, want 0/0/0", gnt, busy, tmo);
    end
    #2 rst_n = 1'b1;
    cyc(5'b10001, 5'b0);
    vectors++;
    if (gnt !== 5'b00001 || gnt_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL mr_pointer: gnt=%b idx=%0d, want 00001/0", gnt, gnt_idx);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int g = 0; g < 256; g++) begin
      cyc(5'b11111, 5'b0);
      vectors++;
      if (cnt !== 8'(m_cnt)) begin
        miscompares++;
        $display("FAIL wrap_count[%0d]: cnt=%0d, want %0d", g, cnt, m_cnt);
      end
      cyc(5'b11111, gnt);
    end
    vectors++;
    if (cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap_zero: cnt=%0d after 256 grants, want 0", cnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] r;
    logic [4:0] d;
    logic [4:0] e;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = 5'($urandom) & 5'($urandom);
      case ($urandom % 8)
        0:       d = gnt;
        1:       d = 5'($urandom);
        default: d = ~gnt & 5'($urandom);
      endcase
      cyc(r, d);
      e = m_busy ? (5'b00001 << m_owner) : 5'b0;
      vectors++;
      if ({gnt, busy, tmo, cnt} !== {e, m_busy, m_tmo, 8'(m_cnt)} ||
          (m_busy && gnt_idx !== 3'(m_owner))) begin
        miscompares++;
        $display("FAIL random[%0d]: gnt=%b idx=%0d busy=%b tmo=%b cnt=%0d, want %b/%0d/%b/%b/%0d",
                 c, gnt, gnt_idx, busy, tmo, cnt, e, m_owner, m_busy, m_tmo, m_cnt);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_wrong_done();
    test_reset_midgrant();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
